// File: rtl/sevenseg_pkg.sv
// Shared definitions for the 7-segment reader: glyph table, FSM state encoding
// and the pattern-to-hex lookup function.
package sevenseg_pkg;

    localparam logic [6:0] GLYPH [0:15] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef logic [0:0] state_t;
    localparam state_t SETTLE = 1'b0;
    localparam state_t LOCKED = 1'b1;

    // Returns {err, digit}; unknown patterns give err=1 with digit 0.
    function automatic logic [4:0] seg_to_hex(input logic [6:0] seg);
        logic [4:0] res;
        res = {1'b1, 4'h0};
        for (int i = 0; i < 16; i++) begin
            if (seg == GLYPH[i]) begin
                res = {1'b0, 4'(i)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sevenseg_stable_det.sv
// Samples the segment bus and emits a one-clock decode strobe once the sampled
// pattern has held for STABLE_CYCLES clocks; re-arms when the pattern changes.
module sevenseg_stable_det
    import sevenseg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seg_in,
    output logic       decode,
    output logic [7:0] seg
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [7:0]       seg_q;
    logic [CNT_W-1:0] cnt_r;
    state_t           state_r;
    logic             changed_s;
    logic             at_last_s;

    // A change is a new sample differing from the one currently held.
    always_comb begin
        changed_s = (seg_in != seg_q);
        at_last_s = (cnt_r == CNT_LAST);
        decode    = (state_r == SETTLE) && !changed_s && at_last_s;
        seg       = seg_q;
    end

    // Sampling register, stability counter and SETTLE/LOCKED FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q   <= 8'h00;
            cnt_r   <= '0;
            state_r <= SETTLE;
        end else begin
            seg_q <= seg_in;
            case (state_r)
                SETTLE: begin
                    if (changed_s) begin
                        cnt_r <= '0;
                    end else if (at_last_s) begin
                        state_r <= LOCKED;
                    end else begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                LOCKED: begin
                    if (changed_s) begin
                        cnt_r   <= '0;
                        state_r <= SETTLE;
                    end else begin
                        state_r <= LOCKED;
                    end
                end
                default: begin
                    cnt_r   <= '0;
                    state_r <= SETTLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/sevenseg_reader.sv
// 7-segment to hex reader with stability filter and valid/ready output register.
// Optional macro SEVENSEG_DP_EN: include the decimal point in compare and capture.
module sevenseg_reader
    import sevenseg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_a,
    input  logic       in_b,
    input  logic       in_c,
    input  logic       in_d,
    input  logic       in_e,
    input  logic       in_f,
    input  logic       in_g,
    input  logic       in_dp,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] out_digit,
    output logic       out_err,
    output logic       out_dp,
    output logic       out_ovf
);

    logic       dp_s;
    logic [7:0] seg_in_s;
    logic       decode_s;
    logic [7:0] seg_s;
    logic [4:0] hex_s;
    logic       blank_s;
    logic       load_s;
    logic       room_s;

`ifdef SEVENSEG_DP_EN
    assign dp_s = in_dp;
`else
    logic unused_dp_s;
    assign unused_dp_s = in_dp;
    assign dp_s        = 1'b0;
`endif

    assign seg_in_s = {dp_s, in_a, in_b, in_c, in_d, in_e, in_f, in_g};

    sevenseg_stable_det #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_stable_det (
        .clk    (clk),
        .rst    (rst),
        .seg_in (seg_in_s),
        .decode (decode_s),
        .seg    (seg_s)
    );

    // Blank patterns consume the decode event without producing a result.
    always_comb begin
        hex_s   = seg_to_hex(seg_s[6:0]);
        blank_s = (seg_s[6:0] == SEG_BLANK);
        load_s  = decode_s && !blank_s;
        room_s  = !out_valid || out_ready;
    end

    // Output register with handshake and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_digit <= 4'h0;
            out_err   <= 1'b0;
            out_dp    <= 1'b0;
            out_ovf   <= 1'b0;
        end else if (load_s && room_s) begin
            out_valid <= 1'b1;
            out_digit <= hex_s[3:0];
            out_err   <= hex_s[4];
            out_dp    <= seg_s[7];
        end else if (load_s) begin
            out_ovf <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

endmodule
